// File: rtl/ldst_issue_queue.sv
// ldst_issue_queue: DEPTH-entry elastic queue between the execute lanes and the
// LSU coalescer. Carries load/store warp packets, drops all-zero-mask packets,
// and supports per-warp selective kill (branch/exception flush). A killed head
// is drained internally and is never presented to the LSU.
module ldst_issue_queue #(
  parameter int NUM_LANES = 32,
  parameter int LANE_W    = 64,
  parameter int WARP_W    = 5,
  parameter int SPACE_W   = 2,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_load,
  input  logic                        in_store,
  input  logic [SPACE_W-1:0]          in_space,
  input  logic [WARP_W-1:0]           in_warp,
  input  logic [NUM_LANES-1:0]        in_mask,
  input  logic [NUM_LANES*LANE_W-1:0] in_lanes,
  input  logic                        flush,
  input  logic [WARP_W-1:0]           flush_warp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_load,
  output logic                        out_store,
  output logic [SPACE_W-1:0]          out_space,
  output logic [WARP_W-1:0]           out_warp,
  output logic [NUM_LANES-1:0]        out_mask,
  output logic [NUM_LANES*LANE_W-1:0] out_lanes,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                        load;
    logic                        store;
    logic [SPACE_W-1:0]          space;
    logic [WARP_W-1:0]           warp;
    logic [NUM_LANES-1:0]        mask;
    logic [NUM_LANES*LANE_W-1:0] lanes;
  } entry_t;

  entry_t         ent_q [DEPTH];
  entry_t         ent_d [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic           push_s;
  logic           pop_s;
  logic           head_killed_s;
  logic           in_flushed_s;
  logic [DEPTH-1:0] occupied_s;
  entry_t         in_entry_s;

  // Handshake, push/pop decisions and head-entry read-out.
  always_comb begin
    in_entry_s    = '{load: in_load, store: in_store, space: in_space,
                      warp: in_warp, mask: in_mask, lanes: in_lanes};
    in_ready      = (count_q < CW'(DEPTH)) & ~reset;
    in_flushed_s  = flush & (in_warp == flush_warp);
    push_s        = in_valid & in_ready & (|in_mask) & ~in_flushed_s;
    head_killed_s = (count_q != {CW{1'b0}}) & kill_q[head_q];
    out_valid     = (count_q != {CW{1'b0}}) & ~kill_q[head_q];
    // A killed head leaves regardless of the LSU; a live head only on handshake.
    pop_s         = (out_valid & out_ready) | head_killed_s;
    out_load      = ent_q[head_q].load;
    out_store     = ent_q[head_q].store;
    out_space     = ent_q[head_q].space;
    out_warp      = ent_q[head_q].warp;
    out_mask      = ent_q[head_q].mask;
    out_lanes     = ent_q[head_q].lanes;
    count         = count_q;
  end

  // Mark which slots lie between head and tail (occupied, killed or not).
  always_comb begin
    logic [PW-1:0] off;
    occupied_s = '0;
    off        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off           = PW'(i) - head_q;
      occupied_s[i] = ({1'b0, off} < count_q);
    end
  end

  // Next-state: flush marks kill bits, pop frees the head slot, push fills the tail.
  always_comb begin
    ent_d   = ent_q;
    kill_d  = kill_q;
    head_d  = head_q;
    tail_d  = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush && occupied_s[i] && (ent_q[i].warp == flush_warp)) begin
        kill_d[i] = 1'b1;
      end else begin
        kill_d[i] = kill_q[i];
      end
    end
    if (pop_s) begin
      kill_d[head_q] = 1'b0;
      head_d         = head_q + PW'(1);
    end else begin
      head_d         = head_q;
    end
    if (push_s) begin
      ent_d[tail_q]  = in_entry_s;
      kill_d[tail_q] = 1'b0;
      tail_d         = tail_q + PW'(1);
    end else begin
      tail_d         = tail_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // State registers; reset empties the queue and clears storage so outputs read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      kill_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      kill_q  <= kill_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
